addsub_serial_ovf: RTL and testbench



---
 rtl/addsub_serial_ovf.sv | 139 +++++++++++++
 tb/tb_addsub_serial_ovf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_ovf.sv
// Digit-serial two's-complement add/subtract with carry, overflow, zero and
// negative flags and optional signed saturation; valid/ready on both sides.
module addsub_serial_ovf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_c;
  logic               r_sat;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_ovf;
  logic               r_zero;
  logic               r_neg;

  logic [DIGIT:0]     w_slice;
  logic [WIDTH-1:0]   w_res_next;
  logic [WIDTH-1:0]   w_sat_val;
  logic [WIDTH-1:0]   w_final;
  logic               w_last;
  logic               w_ovf;

  // One digit of A + B' + carry; new digit enters the result from the top.
  assign w_slice    = (DIGIT+1)'(r_a[DIGIT-1:0]) + (DIGIT+1)'(r_b[DIGIT-1:0])
                    + (DIGIT+1)'(r_c);
  assign w_res_next = (r_res >> DIGIT)
                    | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CNT_W'(N - 1));

  // Same-sign operands producing a different-sign result is signed overflow.
  assign w_ovf      = (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
  assign w_sat_val  = r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_final    = (r_sat && w_ovf) ? w_sat_val : w_res_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_c         <= 1'b0;
      r_sat       <= 1'b0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_c        <= sub;
            r_sat      <= sat;
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            r_cnt      <= '0;
            r_res      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_c   <= w_slice[DIGIT];
          r_res <= w_res_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum       <= w_final;
            r_carry     <= w_slice[DIGIT];
            r_ovf       <= w_ovf;
            r_zero      <= (w_final == '0);
            r_neg       <= w_final[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_addsub_serial_ovf.sv
// Bench for addsub_serial_ovf: directed cases on an 8/2 instance plus a
// randomized sweep of WIDTH x DIGIT instances against an arithmetic model.
module tb_addsub_serial_ovf;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Directed instance, WIDTH=8 DIGIT=2
  logic       rst, in_valid, in_ready, sub, sat, out_valid, out_ready;
  logic       carry, overflow, zero, neg;
  logic [7:0] a, b, sum;

  addsub_serial_ovf #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry(carry), .overflow(overflow),
    .zero(zero), .neg(neg)
  );

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic isub, input logic isat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("issue_ready", 32'(in_ready), 32'd1);
    a = ia; b = ib; sub = isub; sat = isat; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); sat = 1'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("latency", 32'(n), 32'd4);
  endtask

  task automatic expect_res(input string tag, input logic [7:0] es, input logic ec,
                            input logic ev, input logic ez, input logic en);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(ev));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_neg"}, 32'(neg), 32'(en));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Randomized sweep over WIDTH in {8,16}, DIGIT in {1,2,4,8}
  for (genvar gw = 0; gw < 2; gw++) begin : g_w
    for (genvar gd = 0; gd < 4; gd++) begin : g_d
      localparam int unsigned W = 8 << gw;
      localparam int unsigned D = 1 << gd;
      logic         s_rst, s_iv, s_ir, s_sub, s_sat, s_ov, s_or;
      logic         s_c, s_v, s_z, s_n;
      logic [W-1:0] s_a, s_b, s_sum;
      bit           done = 1'b0;

      addsub_serial_ovf #(.WIDTH(W), .DIGIT(D)) u (
        .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir),
        .a(s_a), .b(s_b), .sub(s_sub), .sat(s_sat), .out_valid(s_ov),
        .out_ready(s_or), .sum(s_sum), .carry(s_c), .overflow(s_v),
        .zero(s_z), .neg(s_n)
      );

      initial begin
        longint av, bv, sa, sb, ideal, lo, hi, mask, raw, es;
        bit op_sub, op_sat, ec, ev;
        int n;
        s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b0; s_a = '0; s_b = '0;
        s_sub = 1'b0; s_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1 s_rst = 1'b0;
        mask = (longint'(1) << W) - 1;
        hi   = (longint'(1) << (W - 1)) - 1;
        lo   = -(longint'(1) << (W - 1));
        for (int t = 0; t < 12; t++) begin
          av = longint'($urandom) & mask;
          bv = longint'($urandom) & mask;
          if (t == 0) begin av = hi; bv = 1; end
          if (t == 1) begin av = longint'(1) << (W - 1); bv = 1; end
          op_sub = (t == 1) ? 1'b1 : 1'($urandom);
          op_sat = (t < 2) ? 1'b1 : 1'($urandom);
          sa = (av > hi) ? av - (mask + 1) : av;
          sb = (bv > hi) ? bv - (mask + 1) : bv;
          ideal = op_sub ? sa - sb : sa + sb;
          ev = (ideal > hi) || (ideal < lo);
          ec = op_sub ? (av >= bv) : ((av + bv) > mask);
          raw = (op_sub ? av - bv : av + bv) & mask;
          es = (op_sat && ev) ? ((ideal < 0) ? (hi + 1) : hi) : raw;

          n = 0;
          while (!s_ir && n < 100) begin @(posedge clk); #1; n++; end
          s_a = W'(av); s_b = W'(bv); s_sub = op_sub; s_sat = op_sat; s_iv = 1'b1;
          @(posedge clk); #1;
          s_iv = 1'b0; s_a = W'($urandom); s_b = W'($urandom);
          s_sub = 1'($urandom); s_sat = 1'($urandom);
          n = 0;
          while (!s_ov && n < 100) begin @(posedge clk); #1; n++; end
          check($sformatf("sw%0d_%0d_lat", W, D), 32'(n), 32'(W / D));
          check($sformatf("sw%0d_%0d_sum", W, D), 32'(s_sum), 32'(es));
          check($sformatf("sw%0d_%0d_carry", W, D), 32'(s_c), 32'(ec));
          check($sformatf("sw%0d_%0d_ovf", W, D), 32'(s_v), 32'(ev));
          check($sformatf("sw%0d_%0d_zero", W, D), 32'(s_z), 32'(es == 0));
          check($sformatf("sw%0d_%0d_neg", W, D), 32'(s_n), 32'((es >> (W - 1)) & 1));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1 s_or = 1'b1;
          @(posedge clk); #1;
          s_or = 1'b0;
          check($sformatf("sw%0d_%0d_rel", W, D), 32'({s_ir, s_ov}), 32'b10);
        end
        done = 1'b1;
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outs", 32'({sum, carry, overflow, zero, neg}), 32'd0);
    rst = 1'b0;

    issue(8'h7F, 8'h01, 1'b0, 1'b0); expect_res("add_ovf", 8'h80, 0, 1, 0, 1); release_out();
    issue(8'h7F, 8'h01, 1'b0, 1'b1); expect_res("add_sat", 8'h7F, 0, 1, 0, 0); release_out();
    issue(8'h80, 8'h01, 1'b1, 1'b0); expect_res("sub_ovf", 8'h7F, 1, 1, 0, 0); release_out();
    issue(8'h80, 8'h01, 1'b1, 1'b1); expect_res("sub_sat", 8'h80, 1, 1, 0, 1); release_out();
    issue(8'h05, 8'h03, 1'b1, 1'b0); expect_res("sub_pos", 8'h02, 1, 0, 0, 0); release_out();
    issue(8'h03, 8'h05, 1'b1, 1'b0); expect_res("sub_neg", 8'hFE, 0, 0, 0, 1); release_out();
    issue(8'hFF, 8'h01, 1'b0, 1'b0); expect_res("add_wrap", 8'h00, 1, 0, 1, 0);

    // Hold in DONE with a competing request that must be ignored
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      check("hold_state", 32'({out_valid, in_ready}), 32'b10);
      check("hold_outs", 32'({sum, carry, overflow, zero, neg}), 32'({8'h00, 4'b1010}));
    end
    in_valid = 1'b0;
    release_out();

    // Reset during the second RUN cycle
    a = 8'h12; b = 8'h34; sub = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 32'({in_ready, out_valid}), 32'b10);
    check("mid_rst_outs", 32'({sum, carry, overflow, zero, neg}), 32'd0);
    issue(8'h12, 8'h34, 1'b0, 1'b0); expect_res("post_rst", 8'h46, 0, 0, 0, 0); release_out();

    t = 0;
    while (!(g_w[0].g_d[0].done && g_w[0].g_d[1].done && g_w[0].g_d[2].done &&
             g_w[0].g_d[3].done && g_w[1].g_d[0].done && g_w[1].g_d[1].done &&
             g_w[1].g_d[2].done && g_w[1].g_d[3].done) && t < 50000) begin
      @(posedge clk); t++;
    end
    check("sweep_done", 32'(t < 50000), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
